outputdev_scan: RTL
===================

// Module: outputdev_scan
// PURPOSE
//  Parametrised memory-mapped output device behind the bridge: NCH 32-bit channel registers written by the CPU.
//  Channel registers are double-buffered: CPU writes the shadow copy; commit copies shadow->active only at a
//  scan-frame boundary, so the time-multiplexed display (LED / 7-seg digits) never tears.
//  A prescaled scan counter walks the active channels and drives one-hot select plus channel data to the pins.
// PARAMETERS
//  NCH      4      number of channels (2..16)
//  DW       8      width of ch_data driven to pins (low DW bits of active channel, DW<=32)
//  SCAN_DIV 50000  clk cycles per channel slot (>=2)
//  ADDR_W   3      register address width; must satisfy 2**ADDR_W >= NCH+2
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  we           in   1       write strobe from bridge
//  addr         in   ADDR_W  register select
//  din          in   32      write data from CPU
//  be           in   4       byte enables for shadow writes (be[i] -> din[8i+7:8i])
//  dout         out  32      read data to bridge (combinational from addr)
//  ch_sel       out  NCH     one-hot select of the channel currently driven
//  ch_data      out  DW      active[idx][DW-1:0]
//  frame_start  out  1       1-cycle pulse, first cycle of each frame (idx==0)
// BEHAVIOUR
//  Map: addr 0..NCH-1 = SHADOW[n]; NCH = CTRL; NCH+1 = STATUS; all other addr: reads 0, writes ignored.
//  CTRL: bit0 COMMIT (write-1 requests commit, not stored), bit1 AUTO (stored). Read: {30'b0, AUTO, pending}.
//  STATUS (read-only): [0] pending, [11:8] idx, others 0. Writes ignored.
//  SHADOW read returns shadow value, not active. be ignored for CTRL.
//  Reset: shadow/active all 0, AUTO=0, pending=0, idx=0, prescaler=0, frame_start=0; so ch_sel=1, ch_data=0.
//  Shadow write: bytes with be set updated at the edge. If AUTO=1, pending is also set at that edge.
//  CTRL write with din[0]=1 sets pending (idempotent if already set).
//  Prescaler counts 0..SCAN_DIV-1; tick when cnt==SCAN_DIV-1, then cnt wraps to 0.
//  On tick: idx <= (idx==NCH-1) ? 0 : idx+1. ch_sel = 1<<idx; ch_data from active[idx] (combinational).
//  Wrap edge = tick with idx==NCH-1. At wrap edge: frame_start<=1 (for exactly the next cycle);
//   if pending, active[all] <= shadow[all] (pre-edge values) and pending<=0. Commit latency therefore
//   0..NCH*SCAN_DIV cycles; new data visible from the first cycle of the new frame.
//  Simultaneous at wrap edge: shadow write -> active takes OLD shadow; pending ends 1 if AUTO=1 else
//   follows prior pending (cleared if it was set). COMMIT write on wrap edge -> not applied this edge;
//   pending ends 1, applied next frame. Read of STATUS in that cycle shows pre-edge values.
//  Channel data never changes mid-frame; active only changes at wrap edges or reset.
//  Reset mid-frame: pending commit discarded, scan restarts at idx 0; no frame_start pulse after reset
//   until the first wrap edge.
//  dout purely combinational, no latch; undefined addr -> 32'h0.
// STRUCTURE
//  Shared package/header: register offsets (CTRL_OFS=NCH, STATUS_OFS=NCH+1), CTRL bit indices, byte-merge function.
//  One sub-module: outputdev_scan_timer (prescaler + idx counter, outputs tick, wrap, idx); rest inline.
//  Shadow/active as 2-D reg arrays indexed by channel; generate loop for byte-enable merge.
// TESTING  (bench: NCH=4, DW=8, SCAN_DIV=4)
//  Reset then idle 16 cyc -> ch_sel 1,2,4,8 each 4 cyc, ch_data=0, frame_start once per 16 cyc after first wrap.
//  Write SHADOW[2]=32'hA5A5_1234 be=4'b0011 -> read addr2 = 32'h0000_1234; ch_data still 0 (no commit).
//  CTRL write 1 mid-frame -> STATUS[0]=1; at next wrap active updates, pending=0; slot 2 shows 8'h34.
//  AUTO=1, write SHADOW[1]=8'h7E -> no CTRL write needed; slot 1 shows 8'h7E from next frame only.
//  Shadow write on wrap edge with AUTO=1 -> old value shown this frame, new value next frame.
//  Reset asserted with pending=1 mid-frame -> pending=0, idx=0, active=0; read addr 7 -> 0 always.

Source files
------------

// File: rtl/outputdev_scan_pkg.sv
// rtl/outputdev_scan_pkg.sv - register map constants and byte-merge helper for the scan output device
package outputdev_scan_pkg;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_IDX_LSB  = 8;

    function automatic int ctrl_ofs(input int nch);
        return nch;
    endfunction

    function automatic int status_ofs(input int nch);
        return nch + 1;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/outputdev_scan_if.sv
// rtl/outputdev_scan_if.sv - bridge-side register bus between CPU bridge and the scan output device
interface outputdev_scan_if #(
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [3:0]        be;
    logic [31:0]       dout;

    modport master (output we, addr, din, be, input dout);
    modport slave  (input we, addr, din, be, output dout);
endinterface

// File: rtl/outputdev_scan_timer.sv
// rtl/outputdev_scan_timer.sv - slot prescaler and channel index counter for the display scan
module outputdev_scan_timer #(
    parameter int NCH      = 4,
    parameter int SCAN_DIV = 50000,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic             wrap,
    output logic [IDX_W-1:0] idx
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NCH - 1));
    assign idx  = idx_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/outputdev_scan.sv
// rtl/outputdev_scan.sv - double-buffered channel registers driving a time-multiplexed display scan
module outputdev_scan
    import outputdev_scan_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int SCAN_DIV = 50000,
    parameter int ADDR_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    outputdev_scan_if.slave  bus,
    output logic [NCH-1:0]   ch_sel,
    output logic [DW-1:0]    ch_data,
    output logic             frame_start
);
    localparam int IDX_W = $clog2(NCH);

    logic [31:0] shadow_q [NCH];
    logic [31:0] shadow_d [NCH];
    logic [31:0] active_q [NCH];
    logic [31:0] active_d [NCH];
    logic [31:0] merged   [NCH];
    logic        pending_q, pending_d;
    logic        auto_q, auto_d;
    logic        frame_start_q, frame_start_d;
    logic        shadow_wr, ctrl_wr, frame_edge;
    logic        tick, wrap;
    logic [IDX_W-1:0] idx;

    outputdev_scan_timer #(
        .NCH      (NCH),
        .SCAN_DIV (SCAN_DIV),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .wrap  (wrap),
        .idx   (idx)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_merge
        assign merged[g] = byte_merge(shadow_q[g], bus.din, bus.be);
    end

    assign frame_edge = tick && wrap;
    assign ctrl_wr    = bus.we && (bus.addr == ADDR_W'(ctrl_ofs(NCH)));

    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        auto_d        = auto_q;
        shadow_wr     = 1'b0;
        frame_start_d = frame_edge;
        for (int n = 0; n < NCH; n++) begin
            if (bus.we && (bus.addr == ADDR_W'(n))) begin
                shadow_d[n] = merged[n];
                shadow_wr   = 1'b1;
            end
        end
        // Commit uses pre-edge shadow; a request arriving on the same edge waits a frame.
        if (frame_edge && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (ctrl_wr) auto_d = bus.din[CTRL_AUTO_BIT];
        if ((shadow_wr && auto_q) || (ctrl_wr && bus.din[CTRL_COMMIT_BIT])) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NCH; n++) begin
                shadow_q[n] <= '0;
                active_q[n] <= '0;
            end
            pending_q     <= 1'b0;
            auto_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            auto_q        <= auto_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        bus.dout = 32'h0;
        for (int n = 0; n < NCH; n++) begin
            if (bus.addr == ADDR_W'(n)) bus.dout = shadow_q[n];
        end
        if (bus.addr == ADDR_W'(ctrl_ofs(NCH))) begin
            bus.dout[CTRL_AUTO_BIT]   = auto_q;
            bus.dout[CTRL_COMMIT_BIT] = pending_q;
        end
        if (bus.addr == ADDR_W'(status_ofs(NCH))) begin
            bus.dout[STATUS_PEND_BIT]               = pending_q;
            bus.dout[STATUS_IDX_LSB +: IDX_W]       = idx;
        end
    end

    assign ch_sel      = NCH'(1) << idx;
    assign ch_data     = active_q[idx][DW-1:0];
    assign frame_start = frame_start_q;
endmodule
